// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the dmem arbiter: two request ports sharing one
// ack/err/rdata return path.
interface dmem_arbiter_if #(
    parameter int DBITS = 32
);
    logic [1:0]       req;
    logic [1:0]       we;
    logic [DBITS-1:0] addr0;
    logic [DBITS-1:0] addr1;
    logic [DBITS-1:0] wdata0;
    logic [DBITS-1:0] wdata1;
    logic [1:0]       ack;
    logic             err;
    logic [DBITS-1:0] rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output ack, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Requester 0 is the microcode memory stage, requester 1 the debug/loader port.
// Each access takes three cycles. The memory strobe is high during ISSUE.
// ack is high during RESP, when the memory's registered read data is valid.
// Accesses out of range or misaligned are rejected with err and never reach memory.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures the winner's access
// ISSUE | mem_en/mem_we/mem_addr/mem_wdata presented to dmem (or suppressed if bad)
// RESP  | ack to the winner, err/rdata valid
module dmem_arbiter #(
    parameter int DBITS    = 32,
    parameter int ADDRBITS = 16,
    parameter int WORDBITS = 2,
    parameter int CNTBITS  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    dmem_arbiter_if.slave                bus,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [ADDRBITS-WORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]             mem_wdata,
    input  logic [DBITS-1:0]             mem_rdata,
    output logic [CNTBITS-1:0]           contention
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state;
    logic             last;
    logic             win;
    logic             bad;
    logic             cap_we;
    logic             rd_pass;
    logic [1:0]       ack_q;
    logic             err_q;
    logic [CNTBITS-1:0] cnt;

    logic             pick;
    logic             sel_we;
    logic [DBITS-1:0] sel_addr;
    logic [DBITS-1:0] sel_wdata;
    logic             sel_bad;
    logic             inc;

    // Winner selection and address checks on the requester being granted this cycle
    always_comb begin
        pick = 1'b0;
        if (bus.req == 2'b11)
            pick = ~last;
        else if (bus.req[1])
            pick = 1'b1;
        sel_we    = pick ? bus.we[1] : bus.we[0];
        sel_addr  = pick ? bus.addr1 : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
        sel_bad   = (sel_addr[DBITS-1:ADDRBITS] != '0) || (sel_addr[WORDBITS-1:0] != '0);
    end

    // A cycle counts as contention when the non-served requester is waiting
    always_comb begin
        inc = 1'b0;
        if (state == IDLE)
            inc = (bus.req == 2'b11);
        else
            inc = win ? bus.req[0] : bus.req[1];
    end

    // Arbitration FSM with registered memory strobes, ack and contention counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            win       <= 1'b0;
            bad       <= 1'b0;
            cap_we    <= 1'b0;
            rd_pass   <= 1'b0;
            ack_q     <= 2'b00;
            err_q     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
        end else begin
            if (inc && (cnt != '1))
                cnt <= cnt + CNTBITS'(1);
            case (state)
                IDLE: begin
                    ack_q   <= 2'b00;
                    err_q   <= 1'b0;
                    rd_pass <= 1'b0;
                    if (bus.req != 2'b00) begin
                        win    <= pick;
                        if (bus.req == 2'b11)
                            last <= pick;
                        cap_we <= sel_we;
                        bad    <= sel_bad;
                        mem_en <= ~sel_bad;
                        mem_we <= sel_we & ~sel_bad;
                        if (!sel_bad) begin
                            mem_addr  <= sel_addr[ADDRBITS-1:WORDBITS];
                            mem_wdata <= sel_wdata;
                        end
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    ack_q   <= win ? 2'b10 : 2'b01;
                    err_q   <= bad;
                    rd_pass <= ~bad & ~cap_we;
                    state   <= RESP;
                end
                RESP: begin
                    ack_q   <= 2'b00;
                    err_q   <= 1'b0;
                    rd_pass <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // dmem returns read data one cycle after the strobe, i.e. during RESP
    assign bus.rdata  = rd_pass ? mem_rdata : '0;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign contention = cnt;

endmodule
